load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 14, word-address width driven to data memory.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_valid  input  1  pipeline requests a memory operation this cycle.
REQ-005 i_store  input  1  1 = store, 0 = load; ignored when i_fence_i is high.
REQ-006 i_fence_i  input  1  request instruction-memory synchronisation; has priority over load/store.
REQ-007 i_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_addr  input  32  byte address.
REQ-009 i_wdata  input  32  store data, right-aligned.
REQ-010 o_accept  output  1  request consumed this cycle.
REQ-011 o_rvalid  output  1  one-cycle pulse; o_rdata holds load result.
REQ-012 o_rdata  output  32  aligned, extended load result.
REQ-013 o_fault  output  1  one-cycle pulse; request is misaligned or has an illegal funct3.
REQ-014 o_busy  output  1  unit is not in IDLE.
REQ-015 o_dm_ren / o_dm_wen  output  1 each  data-memory read and write strobes.
REQ-016 o_dm_ben  output  4  byte enables; bit n maps to wdata[8n+7:8n].
REQ-017 o_dm_addr  output  ADDR_W  word address, i_addr[ADDR_W+1:2].
REQ-018 o_dm_wdata  output  32  lane-replicated store data.
REQ-019 i_dm_rdata  input  32  memory read data, valid one cycle after o_dm_ren.
REQ-020 o_fence_i  output  1  one-cycle sync request to memory.
REQ-021 i_ready  input  1  memory can accept an access this cycle.

Function
REQ-022 States SHALL be IDLE, LOAD_WAIT, FENCE_ISSUED, and FENCE_WAIT.
REQ-023 In IDLE, a request is accepted (o_accept=1) only when i_valid && i_ready; otherwise no strobe is driven and the request is held by the pipeline.
REQ-024 Fault check before access: H/HU with addr[0]=1, W with addr[1:0]!=0, load funct3 in {011,110,111}, or store funct3 >010 -> o_fault=1 and o_accept=1 in the same cycle, no strobe, stay IDLE.
REQ-025 Store: on acceptance, o_dm_wen=1 combinationally that cycle; byte ben=0001<<addr[1:0] with wdata={4{byte}}; half ben=addr[1]?1100:0011 with wdata={2{half}}; word ben=1111; stay IDLE (one store per cycle).
REQ-026 Load: on acceptance, o_dm_ren=1 and the state goes to LOAD_WAIT, registering funct3 and addr[1:0].
REQ-027 LOAD_WAIT: select the lane from i_dm_rdata using the registered offset; B/H sign-extend, BU/HU zero-extend; o_rvalid=1 with o_rdata; return to IDLE; o_accept=0 in this state.
REQ-028 Fence: on acceptance, o_fence_i=1 for one cycle, then FENCE_ISSUED (one cycle, ignore i_ready), then FENCE_WAIT until i_ready=1, then IDLE.
REQ-029 o_rdata SHALL hold its last value while o_rvalid=0; o_dm_wdata, o_dm_ben and o_dm_addr are don't-care when no strobe is active.
REQ-030 i_valid while o_busy=1 SHALL NOT be accepted.
REQ-031 o_dm_ren, o_dm_wen and o_fence_i SHALL be mutually exclusive.

Reset
REQ-032 Reset SHALL force state to IDLE; o_rvalid, o_fault, o_accept, all strobes and o_fence_i=0; o_rdata=0.
REQ-033 Reset asserted in LOAD_WAIT or FENCE_WAIT SHALL discard the operation with no o_rvalid pulse.

Structure
REQ-034 Package funrv32_pkg SHALL hold the funct3 width constants, the state encoding, and the fault conditions.
REQ-035 A single combinational sub-module, load_align (rdata, offset, funct3 -> extended result), SHALL be used.

Verification
REQ-036 SB addr=0x00000007, wdata=0x000000A5, i_ready=1 -> same cycle: wen=1, ben=1000, dm_addr=1, dm_wdata=0xA5A5A5A5.
REQ-037 LB addr=0x2, i_dm_rdata=0x11803322 next cycle -> o_rvalid=1, o_rdata=0xFFFFFF80; same with LBU -> 0x00000080.
REQ-038 LW addr=0x6 -> o_fault=1, o_accept=1, no ren/wen; then LHU addr=0x6 with rdata=0xBEEF0000 -> o_rdata=0x0000BEEF.
REQ-039 i_fence_i=1, i_ready driven 1,0,0,0,1 -> o_fence_i pulse, o_busy high until the cycle i_ready=1, and a subsequent SW is accepted only after that.
REQ-040 Load accepted, i_rst=1 in LOAD_WAIT -> no o_rvalid, IDLE next cycle; also i_valid with i_ready=0 for 3 cycles -> o_accept=0 and no strobes.

Source files
------------

// File: rtl/funrv32_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding
// and the request fault rule.
package funrv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_LOAD_WAIT    = 2'd1,
        ST_FENCE_ISSUED = 2'd2,
        ST_FENCE_WAIT   = 2'd3
    } lsu_state_t;

    // Illegal width code for the direction, or an access not naturally aligned.
    function automatic logic lsu_fault(input logic       store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic bad_code;
        logic misaligned;
        bad_code   = store ? (funct3 > F3_W)
                           : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset[0])
                  || ((funct3 == F3_W) && (offset != 2'b00));
        return bad_code || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load result formatter: picks the addressed byte/half lane out of a memory
// word and sign- or zero-extends it according to funct3.
module load_align
    import funrv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[8*offset +: 8];
    assign lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: result is assigned on every path through the case, so no latch is inferred.
    always_comb begin
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   result = {24'd0, lane_b};
            F3_HU:   result = {16'd0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-cycle stores, two-cycle loads and an
// instruction-fence handshake towards the memory system.
module load_store_unit
    import funrv32_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_store,
    input  logic              i_fence_i,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_accept,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_fault,
    output logic              o_busy,
    output logic              o_dm_ren,
    output logic              o_dm_wen,
    output logic [3:0]        o_dm_ben,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    input  logic [31:0]       i_dm_rdata,
    output logic              o_fence_i,
    input  logic              i_ready
);

    lsu_state_t  state;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_off_q;
    logic [31:0] rdata_q;
    logic [31:0] aligned;

    logic take, req_fault, do_fence, do_store, do_load;

    // Same-cycle handshake; gating with i_rst keeps every strobe low during reset.
    assign take      = (state == ST_IDLE) && !i_rst && i_valid && i_ready;
    assign do_fence  = take && i_fence_i;
    assign req_fault = take && !i_fence_i && lsu_fault(i_store, i_funct3, i_addr[1:0]);
    assign do_store  = take && !i_fence_i && !req_fault && i_store;
    assign do_load   = take && !i_fence_i && !req_fault && !i_store;

    assign o_accept  = take;
    assign o_fault   = req_fault;
    assign o_fence_i = do_fence;
    assign o_dm_wen  = do_store;
    assign o_dm_ren  = do_load;
    assign o_busy    = (state != ST_IDLE);
    assign o_dm_addr = i_addr[ADDR_W+1:2];

    always_comb begin
        o_dm_ben   = 4'b1111;
        o_dm_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_dm_ben   = 4'b0001 << i_addr[1:0];
                o_dm_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_dm_ben   = i_addr[1] ? 4'b1100 : 4'b0011;
                o_dm_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_align (
        .rdata  (i_dm_rdata),
        .offset (ld_off_q),
        .funct3 (ld_funct3_q),
        .result (aligned)
    );

    // Memory data arrives during LOAD_WAIT, so the result is forwarded that cycle
    // and captured so o_rdata holds it afterwards.
    assign o_rvalid = (state == ST_LOAD_WAIT) && !i_rst;
    assign o_rdata  = o_rvalid ? aligned : rdata_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            ld_funct3_q <= 3'd0;
            ld_off_q    <= 2'd0;
            rdata_q     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_load) begin
                        state       <= ST_LOAD_WAIT;
                        ld_funct3_q <= i_funct3;
                        ld_off_q    <= i_addr[1:0];
                    end else if (do_fence) begin
                        state <= ST_FENCE_ISSUED;
                    end
                end
                ST_LOAD_WAIT: begin
                    rdata_q <= aligned;
                    state   <= ST_IDLE;
                end
                ST_FENCE_ISSUED: state <= ST_FENCE_WAIT;
                ST_FENCE_WAIT: begin
                    if (i_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a load-result
// scoreboard, plus directed fence, stall and reset-during-load sequences.
module tb_load_store_unit;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_valid, i_store, i_fence_i, i_ready;
    logic [2:0]        i_funct3;
    logic [31:0]       i_addr, i_wdata, i_dm_rdata;
    logic              o_accept, o_rvalid, o_fault, o_busy;
    logic              o_dm_ren, o_dm_wen, o_fence_i;
    logic [31:0]       o_rdata, o_dm_wdata;
    logic [3:0]        o_dm_ben;
    logic [ADDR_W-1:0] o_dm_addr;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_store    (i_store),
        .i_fence_i  (i_fence_i),
        .i_funct3   (i_funct3),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_accept   (o_accept),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .o_fault    (o_fault),
        .o_busy     (o_busy),
        .o_dm_ren   (o_dm_ren),
        .o_dm_wen   (o_dm_wen),
        .o_dm_ben   (o_dm_ben),
        .o_dm_addr  (o_dm_addr),
        .o_dm_wdata (o_dm_wdata),
        .i_dm_rdata (i_dm_rdata),
        .o_fence_i  (o_fence_i),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid   = 1'b0;
        i_store   = 1'b0;
        i_fence_i = 1'b0;
        i_funct3  = 3'b000;
        i_addr    = 32'd0;
        i_wdata   = 32'd0;
    endtask

    // Scoreboard: every load result pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (o_rvalid) begin
            if (sb.size() == 0)
                check("rvalid_unexpected", {31'd0, o_rvalid}, 32'd0);
            else
                check("load_rdata", o_rdata, sb.pop_front());
        end
        if (!i_rst)
            check("strobe_exclusive", {31'd0, ({2'b00, o_dm_ren} + {2'b00, o_dm_wen}
                                              + {2'b00, o_fence_i}) <= 3'd1}, 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        fault;
        logic [3:0]  ben;
        logic [31:0] dm_wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //           st    f3      addr          wdata         mem           flt   ben      dm_wdata      rdata
        vecs[0]  = '{1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[1]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[2]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_0004, 32'h0000_005C, 32'h0,        1'b0, 4'b0001, 32'h5C5C_5C5C, 32'h0};
        vecs[4]  = '{1'b0, 3'b000, 32'h0000_0002, 32'h0,         32'h1180_3322, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[5]  = '{1'b0, 3'b100, 32'h0000_0002, 32'h0,         32'h1180_3322, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_0006, 32'h0,         32'hBEEF_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_BEEF};
        vecs[8]  = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,         32'h1234_8001, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D};
        vecs[10] = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_1111, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00FF, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 3'b110, 32'h0000_0004, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_0003, 32'h0,         32'h7F00_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_007F};
        vecs[15] = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_FFFF, 1'b0, 4'b0000, 32'h0,        32'h0000_FFFF};

        // Reset state
        idle_inputs();
        i_ready    = 1'b1;
        i_dm_rdata = 32'h0;
        i_rst      = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   {31'd0, o_busy},   32'd0);
        check("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
        check("rst_accept", {31'd0, o_accept}, 32'd0);
        check("rst_fault",  {31'd0, o_fault},  32'd0);
        check("rst_rdata",  o_rdata,           32'd0);

        // Table-driven requests
        for (int i = 0; i < 16; i++) begin
            step();
            i_valid   = 1'b1;
            i_store   = vecs[i].store;
            i_fence_i = 1'b0;
            i_funct3  = vecs[i].f3;
            i_addr    = vecs[i].addr;
            i_wdata   = vecs[i].wdata;
            i_ready   = 1'b1;
            @(negedge clk);
            check("vec_accept", {31'd0, o_accept}, 32'd1);
            check("vec_fault",  {31'd0, o_fault},  {31'd0, vecs[i].fault});
            check("vec_wen",    {31'd0, o_dm_wen}, {31'd0, vecs[i].store && !vecs[i].fault});
            check("vec_ren",    {31'd0, o_dm_ren}, {31'd0, !vecs[i].store && !vecs[i].fault});
            check("vec_addr",   {{(32-ADDR_W){1'b0}}, o_dm_addr}, {18'd0, vecs[i].addr[15:2]});
            if (vecs[i].store && !vecs[i].fault) begin
                check("vec_ben",   {28'd0, o_dm_ben}, {28'd0, vecs[i].ben});
                check("vec_wdata", o_dm_wdata,        vecs[i].dm_wdata);
            end
            if (!vecs[i].store && !vecs[i].fault) begin
                sb.push_back(vecs[i].rdata);
                step();
                idle_inputs();
                i_dm_rdata = vecs[i].mem;
                @(negedge clk);
                check("vec_rvalid", {31'd0, o_rvalid}, 32'd1);
                check("vec_lw_acc", {31'd0, o_accept}, 32'd0);
                step();
                i_dm_rdata = $urandom;
                @(negedge clk);
                check("vec_rdata_hold", o_rdata, vecs[i].rdata);
                check("vec_sb_drained", sb.size(), 32'd0);
            end else begin
                step();
                idle_inputs();
                @(negedge clk);
                check("vec_busy_after", {31'd0, o_busy}, 32'd0);
            end
        end

        // Fence handshake with i_ready 1,0,0,0,1; a store waits behind it
        step();
        i_valid   = 1'b1;
        i_fence_i = 1'b1;
        i_store   = 1'b1;
        i_funct3  = 3'b111;
        i_ready   = 1'b1;
        @(negedge clk);
        check("fence_pulse",  {31'd0, o_fence_i}, 32'd1);
        check("fence_accept", {31'd0, o_accept},  32'd1);
        check("fence_fault",  {31'd0, o_fault},   32'd0);
        check("fence_wen",    {31'd0, o_dm_wen},  32'd0);
        for (int c = 1; c <= 4; c++) begin
            step();
            i_fence_i = 1'b0;
            i_funct3  = 3'b010;
            i_addr    = 32'h0000_0020;
            i_wdata   = 32'h0BAD_F00D;
            i_ready   = (c == 4);
            @(negedge clk);
            check("fence_busy",      {31'd0, o_busy},    32'd1);
            check("fence_sw_held",   {31'd0, o_accept},  32'd0);
            check("fence_no_wen",    {31'd0, o_dm_wen},  32'd0);
            check("fence_one_pulse", {31'd0, o_fence_i}, 32'd0);
        end
        step();
        @(negedge clk);
        check("sw_after_busy",   {31'd0, o_busy},   32'd0);
        check("sw_after_accept", {31'd0, o_accept}, 32'd1);
        check("sw_after_wen",    {31'd0, o_dm_wen}, 32'd1);
        check("sw_after_ben",    {28'd0, o_dm_ben}, 32'hF);

        // Requests stalled by i_ready low for three cycles
        for (int c = 0; c < 3; c++) begin
            step();
            i_valid = 1'b1;
            i_store = c[0];
            i_funct3 = 3'b010;
            i_addr  = 32'h0000_0040;
            i_ready = 1'b0;
            @(negedge clk);
            check("stall_accept", {31'd0, o_accept}, 32'd0);
            check("stall_ren",    {31'd0, o_dm_ren}, 32'd0);
            check("stall_wen",    {31'd0, o_dm_wen}, 32'd0);
        end

        // Reset while in LOAD_WAIT discards the load
        step();
        i_valid  = 1'b1;
        i_store  = 1'b0;
        i_funct3 = 3'b000;
        i_addr   = 32'h0000_0001;
        i_ready  = 1'b1;
        @(negedge clk);
        check("rstlw_ren", {31'd0, o_dm_ren}, 32'd1);
        step();
        idle_inputs();
        i_dm_rdata = 32'h5555_5555;
        i_rst      = 1'b1;
        @(negedge clk);
        check("rstlw_no_rvalid", {31'd0, o_rvalid}, 32'd0);
        step();
        i_rst = 1'b0;
        @(negedge clk);
        check("rstlw_idle",   {31'd0, o_busy},   32'd0);
        check("rstlw_rvalid", {31'd0, o_rvalid}, 32'd0);
        check("rstlw_rdata",  o_rdata,           32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
